// File: rtl/led7seg_74hc595_receiver.sv
// Receive side of the 74HC595 LED7seg serial link: oversamples sclk/rclk/dio,
// reassembles digit words, collects a full frame and decodes segments back to BCD.

module led7seg_digit_decode (
  input  logic [6:0] seg,
  output logic [3:0] bcd,
  output logic       ok
);
  // Active-low patterns; dp is not part of the lookup.
  always_comb begin
    bcd = 4'hF;
    ok  = 1'b0;
    case (seg)
      7'h40: begin bcd = 4'd0; ok = 1'b1; end
      7'h79: begin bcd = 4'd1; ok = 1'b1; end
      7'h24: begin bcd = 4'd2; ok = 1'b1; end
      7'h30: begin bcd = 4'd3; ok = 1'b1; end
      7'h19: begin bcd = 4'd4; ok = 1'b1; end
      7'h12: begin bcd = 4'd5; ok = 1'b1; end
      7'h02: begin bcd = 4'd6; ok = 1'b1; end
      7'h78: begin bcd = 4'd7; ok = 1'b1; end
      7'h00: begin bcd = 4'd8; ok = 1'b1; end
      7'h10: begin bcd = 4'd9; ok = 1'b1; end
      default: begin bcd = 4'hF; ok = 1'b0; end
    endcase
  end
endmodule

module led7seg_74hc595_receiver #(
  parameter int DIG_NUM     = 8,
  parameter int SEG_NUM     = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sclk,
  input  logic                       rclk,
  input  logic                       dio,
  output logic [DIG_NUM*SEG_NUM-1:0] dat,
  output logic                       vld,
  output logic [4*DIG_NUM-1:0]       bcd,
  output logic [DIG_NUM-1:0]         bcd_ok,
  output logic                       err
);
  localparam int WORD_W  = SEG_NUM + DIG_NUM;
  localparam int CNT_MAX = WORD_W + 1;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;

  // Line index: 0 = sclk, 1 = rclk, 2 = dio
  logic [2:0]                  pins;
  logic [2:0][SYNC_STAGES-1:0] sync_q;
  logic [2:0]                  line_s;
  logic [1:0]                  prev_q;
  logic                        sclk_rise, rclk_rise, dio_s;

  assign pins = {dio, rclk, sclk};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      for (int i = 0; i < 3; i++)
        sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], pins[i]};
      prev_q <= line_s[1:0];
    end
  end

  always_comb begin
    line_s = '0;
    for (int i = 0; i < 3; i++) line_s[i] = sync_q[i][SYNC_STAGES-1];
  end

  assign sclk_rise = line_s[0] & ~prev_q[0];
  assign rclk_rise = line_s[1] & ~prev_q[1];
  assign dio_s     = line_s[2];

  state_t              state_q, state_d;
  logic [WORD_W-1:0]   shreg_q, word_q;
  logic [CNT_W-1:0]    bit_cnt_q, word_cnt_q;

  // On a simultaneous sclk/rclk rise the latch sees the pre-shift register and
  // the new bit becomes bit 1 of the following word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      word_q     <= '0;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (sclk_rise) shreg_q <= {shreg_q[WORD_W-2:0], dio_s};
      if (rclk_rise) begin
        word_q     <= shreg_q;
        word_cnt_q <= bit_cnt_q;
        bit_cnt_q  <= sclk_rise ? CNT_W'(1) : '0;
      end else if (sclk_rise && bit_cnt_q != CNT_W'(CNT_MAX)) begin
        bit_cnt_q <= bit_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (rclk_rise) state_d = CHECK;
               else if (sclk_rise) state_d = SHIFT;
      SHIFT:   if (rclk_rise) state_d = CHECK;
      CHECK:   if (rclk_rise) state_d = CHECK;
               else if (sclk_rise || bit_cnt_q != '0) state_d = SHIFT;
               else state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  logic [SEG_NUM-1:0]                frame_seg;
  logic [DIG_NUM-1:0]                word_sel, mask_q;
  logic [DIG_NUM-1:0][SEG_NUM-1:0]   frame_q;
  logic                              sel_onehot, accept, reject, frame_done;
  logic [DIG_NUM-1:0][3:0]           dec_bcd;
  logic [DIG_NUM-1:0]                dec_ok;

  assign frame_seg  = word_q[WORD_W-1 -: SEG_NUM];
  assign word_sel   = word_q[DIG_NUM-1:0];
  assign sel_onehot = (word_sel != '0) && ((word_sel & (word_sel - 1'b1)) == '0);
  assign accept     = (state_q == CHECK) && (word_cnt_q == CNT_W'(WORD_W)) && sel_onehot;
  assign reject     = (state_q == CHECK) && !accept;
  assign frame_done = &mask_q;

  for (genvar g = 0; g < DIG_NUM; g++) begin : g_dec
    led7seg_digit_decode u_dec (
      .seg (frame_q[g][6:0]),
      .bcd (dec_bcd[g]),
      .ok  (dec_ok[g])
    );
  end

  // The select field doubles as the mask bit to set, so no index decode is needed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_q <= '0;
      mask_q  <= '0;
      dat     <= '0;
      bcd     <= '0;
      bcd_ok  <= '0;
      vld     <= 1'b0;
      err     <= 1'b0;
    end else begin
      vld    <= frame_done;
      err    <= reject;
      mask_q <= (frame_done ? '0 : mask_q) | (accept ? word_sel : '0);
      for (int i = 0; i < DIG_NUM; i++)
        if (accept && word_sel[i]) frame_q[i] <= frame_seg;
      if (frame_done) begin
        dat    <= frame_q;
        bcd    <= dec_bcd;
        bcd_ok <= dec_ok;
      end
    end
  end
endmodule

// File: tb/tb_led7seg_74hc595_receiver.sv
// Bench for led7seg_74hc595_receiver: table of segment patterns plus hand-built
// link sequences; frame expectations go through a queue popped on vld.

module tb_led7seg_74hc595_receiver;
  logic        clk = 1'b0, rst = 1'b1, sclk = 1'b0, rclk = 1'b0, dio = 1'b0;
  logic [63:0] dat;
  logic [31:0] bcd;
  logic [7:0]  bcd_ok;
  logic        vld, err;

  led7seg_74hc595_receiver #(.DIG_NUM(8), .SEG_NUM(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .rclk(rclk), .dio(dio),
    .dat(dat), .vld(vld), .bcd(bcd), .bcd_ok(bcd_ok), .err(err)
  );

  always #4 clk = ~clk;

  typedef struct {
    logic [63:0] dat;
    logic [31:0] bcd;
    logic [7:0]  ok;
  } exp_t;

  typedef struct {
    logic [7:0] seg;
    logic [3:0] bcd;
    logic       ok;
  } vec_t;

  exp_t q[$];
  int   n_cmp = 0, n_bad = 0;
  int   vld_cnt = 0, err_cnt = 0, n_push = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Output monitor / scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (vld || err) chk("vld_err_exclusive", 64'(vld & err), 64'd0);
      if (err) err_cnt++;
      if (vld) begin
        vld_cnt++;
        if (q.size() == 0) chk("unexpected_vld", 64'd1, 64'd0);
        else begin
          exp_t e;
          e = q.pop_front();
          chk("frame_dat", dat, e.dat);
          chk("frame_bcd", 64'(bcd), 64'(e.bcd));
          chk("frame_bcd_ok", 64'(bcd_ok), 64'(e.ok));
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic shift_bit(input logic b);
    dio = b; tick(4); sclk = 1'b1; tick(4); sclk = 1'b0; tick(4);
  endtask

  task automatic latch();
    rclk = 1'b1; tick(4); rclk = 1'b0; tick(4);
  endtask

  task automatic send_bits(input logic [15:0] w, input int n);
    for (int i = 0; i < n; i++) shift_bit(w[15-i]);
  endtask

  task automatic send_word(input logic [7:0] seg, input logic [7:0] sel);
    send_bits({seg, sel}, 16);
    latch();
  endtask

  task automatic push(input exp_t e);
    q.push_back(e);
    n_push++;
  endtask

  function automatic exp_t model_frame(input logic [7:0][7:0] segs);
    logic [6:0] pat [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                             7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    exp_t e;
    e.dat = segs;
    e.bcd = '1;
    e.ok  = '0;
    for (int i = 0; i < 8; i++)
      for (int k = 0; k < 10; k++)
        if (segs[i][6:0] == pat[k]) begin
          e.bcd[4*i +: 4] = 4'(k);
          e.ok[i] = 1'b1;
        end
    return e;
  endfunction

  task automatic send_frame(input logic [7:0][7:0] segs, input exp_t e);
    for (int d = 0; d < 8; d++) begin
      if (d == 7) push(e);
      send_word(segs[d], 8'(1 << d));
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (q.size() != 0 && n < 4000) begin tick(1); n++; end
    tick(10);
    chk(name, 64'(q.size()), 64'd0);
  endtask

  initial begin
    vec_t             tbl [16];
    logic [7:0][7:0]  segs;
    exp_t             e;
    int               e0, v0;
    logic [15:0]      w;

    tbl = '{
      '{8'hC0, 4'd0, 1'b1}, '{8'hF9, 4'd1, 1'b1}, '{8'hA4, 4'd2, 1'b1}, '{8'hB0, 4'd3, 1'b1},
      '{8'h99, 4'd4, 1'b1}, '{8'h92, 4'd5, 1'b1}, '{8'h82, 4'd6, 1'b1}, '{8'hF8, 4'd7, 1'b1},
      '{8'h80, 4'd8, 1'b1}, '{8'h90, 4'd9, 1'b1}, '{8'h40, 4'd0, 1'b1}, '{8'h19, 4'd4, 1'b1},
      '{8'hFF, 4'hF, 1'b0}, '{8'h7F, 4'hF, 1'b0}, '{8'h88, 4'hF, 1'b0}, '{8'h00, 4'd8, 1'b1}
    };

    // Reset state
    tick(5);
    chk("rst_dat", dat, 64'd0);
    chk("rst_bcd", 64'(bcd), 64'd0);
    chk("rst_bcd_ok", 64'(bcd_ok), 64'd0);
    chk("rst_vld", 64'(vld), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    rst = 1'b0;
    tick(5);

    // Test 1: 0 followed by seven 1s
    for (int d = 0; d < 8; d++) segs[d] = (d == 0) ? 8'hC0 : 8'hF9;
    e.dat = segs; e.bcd = 32'h11111110; e.ok = 8'hFF;
    send_frame(segs, e);
    drain("t1_drain");
    chk("t1_bcd", 64'(bcd), 64'h11111110);
    chk("t1_bcd_ok", 64'(bcd_ok), 64'hFF);
    chk("t1_dat0", 64'(dat[7:0]), 64'hC0);

    // Table-driven frames: decoder patterns incl. dp, blank, non-digit
    for (int f = 0; f < 2; f++) begin
      for (int d = 0; d < 8; d++) begin
        segs[d] = tbl[f*8+d].seg;
        e.bcd[4*d +: 4] = tbl[f*8+d].bcd;
        e.ok[d] = tbl[f*8+d].ok;
      end
      e.dat = segs;
      send_frame(segs, e);
      drain("tbl_drain");
    end

    // Test 2: short word (15 bits) rejected; frame waits for digit 0
    for (int d = 0; d < 8; d++) segs[d] = tbl[(d + 2) % 16].seg;
    e0 = err_cnt;
    send_bits({segs[0], 8'h01}, 15);
    latch();
    tick(10);
    chk("t2_err", 64'(err_cnt), 64'(e0 + 1));
    v0 = vld_cnt;
    for (int d = 1; d < 8; d++) send_word(segs[d], 8'(1 << d));
    tick(20);
    chk("t2_no_vld", 64'(vld_cnt), 64'(v0));
    push(model_frame(segs));
    send_word(segs[0], 8'h01);
    drain("t2_drain");

    // Test 3: two-hot select rejected, buffer untouched
    for (int d = 0; d < 8; d++) segs[d] = tbl[(d + 5) % 16].seg;
    for (int d = 0; d < 7; d++) send_word(segs[d], 8'(1 << d));
    e0 = err_cnt;
    send_word(8'h80, 8'h03);
    tick(10);
    chk("t3_err", 64'(err_cnt), 64'(e0 + 1));
    push(model_frame(segs));
    send_word(segs[7], 8'h80);
    drain("t3_drain");

    // Test 4: blank digit 3
    for (int d = 0; d < 8; d++) segs[d] = tbl[d].seg;
    segs[3] = 8'hFF;
    send_frame(segs, model_frame(segs));
    drain("t4_drain");
    chk("t4_bcd3", 64'(bcd[15:12]), 64'hF);
    chk("t4_ok3", 64'(bcd_ok[3]), 64'd0);

    // Test 5: sclk and rclk rise together at the end of digit 6
    for (int d = 0; d < 8; d++) segs[d] = tbl[(d + 9) % 16].seg;
    e0 = err_cnt;
    for (int d = 0; d < 6; d++) send_word(segs[d], 8'(1 << d));
    send_bits({segs[6], 8'h40}, 16);
    w = {segs[7], 8'h80};
    dio = w[15]; tick(4);
    sclk = 1'b1; rclk = 1'b1; tick(4);
    sclk = 1'b0; rclk = 1'b0; tick(4);
    push(model_frame(segs));
    send_bits(w << 1, 15);
    latch();
    drain("t5_drain");
    chk("t5_no_err", 64'(err_cnt), 64'(e0));

    // Test 6: reset after 4 accepted digits drops the partial frame
    for (int d = 4; d < 8; d++) send_word(8'hC0, 8'(1 << d));
    rst = 1'b1; tick(3); rst = 1'b0; tick(5);
    chk("t6_rst_dat", dat, 64'd0);
    chk("t6_rst_ok", 64'(bcd_ok), 64'd0);
    v0 = vld_cnt;
    for (int d = 0; d < 8; d++) segs[d] = tbl[(d + 1) % 16].seg;
    send_frame(segs, model_frame(segs));
    drain("t6_drain");
    chk("t6_one_vld", 64'(vld_cnt), 64'(v0 + 1));

    chk("total_vld", 64'(vld_cnt), 64'(n_push));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
